// File: rtl/uart_report_scheduler.sv
// Round-robin scheduler sharing one decimal-ASCII UART formatter between N_REQ producers.
// Optional build macro UART_SCHED_PRIO0_EN gives requester 0 fixed priority over the rotation.
module uart_report_scheduler #(
   parameter int N_REQ     = 4,
   parameter int DATA_W    = 16,
   parameter int WD_CYCLES = 8
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic [N_REQ-1:0]           req_valid_i,
   input  logic [N_REQ*DATA_W-1:0]    req_data_i,
   output logic [N_REQ-1:0]           req_ready_o,
   output logic [DATA_W-1:0]          fmt_data_o,
   output logic                       fmt_start_o,
   input  logic                       fmt_idle_i,
   output logic [$clog2(N_REQ)-1:0]   grant_id_o,
   output logic                       busy_o,
   output logic                       wd_error_o
);

   localparam int PTR_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(WD_CYCLES + 1);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_ISSUE     = 2'd1;
   localparam logic [1:0] S_WAIT_BUSY = 2'd2;
   localparam logic [1:0] S_WAIT_DONE = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [N_REQ-1:0]  slotFull_q, slotFull_d;
   logic [DATA_W-1:0] slotData_q [N_REQ];
   logic [N_REQ-1:0]  loadVec, clearVec;
   logic [PTR_W-1:0]  rrPtr_q, rrPtr_d;
   logic [PTR_W-1:0]  grant_q, grant_d;
   logic [DATA_W-1:0] fmtData_q, fmtData_d;
   logic [CNT_W-1:0]  wdCnt_q, wdCnt_d;
   logic              wdError_q, wdError_d;
   logic              pickValid;
   logic [PTR_W-1:0]  pickIdx;
   logic [PTR_W-1:0]  idxSel;
   logic [PTR_W-1:0]  rrNext;

   // A slot only loads while empty and only clears while full, so load and clear never collide.
   assign loadVec    = req_valid_i & ~slotFull_q;
   assign slotFull_d = (slotFull_q | loadVec) & ~clearVec;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         slotFull_q <= '0;
         for (int i = 0; i < N_REQ; i++) slotData_q[i] <= '0;
      end else begin
         slotFull_q <= slotFull_d;
         for (int i = 0; i < N_REQ; i++) begin
            if (loadVec[i]) slotData_q[i] <= req_data_i[i*DATA_W +: DATA_W];
         end
      end
   end

   // Scan downward so the closest full slot at or after rrPtr_q is the last one written.
   always_comb begin
      pickValid = 1'b0;
      pickIdx   = '0;
      idxSel    = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idxSel = PTR_W'((int'(rrPtr_q) + k) % N_REQ);
`ifdef UART_SCHED_PRIO0_EN
         if (slotFull_q[idxSel] && (idxSel != '0)) begin
`else
         if (slotFull_q[idxSel]) begin
`endif
            pickValid = 1'b1;
            pickIdx   = idxSel;
         end
      end
`ifdef UART_SCHED_PRIO0_EN
      if (slotFull_q[0]) begin
         pickValid = 1'b1;
         pickIdx   = '0;
      end
`endif
   end

   assign rrNext = (grant_q == PTR_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      fmtData_d = fmtData_q;
      rrPtr_d   = rrPtr_q;
      wdCnt_d   = wdCnt_q;
      wdError_d = wdError_q;
      clearVec  = '0;
      case (state_q)
         S_IDLE: begin
            if (pickValid && fmt_idle_i) begin
               grant_d   = pickIdx;
               fmtData_d = slotData_q[pickIdx];
               state_d   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            wdCnt_d = '0;
            state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            // On expiry the slot stays full and rrPtr_q is untouched, so the same requester retries.
            if (!fmt_idle_i) begin
               state_d = S_WAIT_DONE;
            end else if (wdCnt_q == CNT_W'(WD_CYCLES - 1)) begin
               wdError_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               wdCnt_d = wdCnt_q + 1'b1;
            end
         end
         S_WAIT_DONE: begin
            if (fmt_idle_i) begin
               clearVec[grant_q] = 1'b1;
               state_d           = S_IDLE;
`ifdef UART_SCHED_PRIO0_EN
               if (grant_q != '0) rrPtr_d = rrNext;
`else
               rrPtr_d = rrNext;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         grant_q   <= '0;
         fmtData_q <= '0;
         rrPtr_q   <= '0;
         wdCnt_q   <= '0;
         wdError_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         fmtData_q <= fmtData_d;
         rrPtr_q   <= rrPtr_d;
         wdCnt_q   <= wdCnt_d;
         wdError_q <= wdError_d;
      end
   end

   assign req_ready_o = ~slotFull_q;
   assign fmt_data_o  = fmtData_q;
   assign fmt_start_o = (state_q == S_ISSUE);
   assign grant_id_o  = grant_q;
   assign busy_o      = (state_q != S_IDLE);
   assign wd_error_o  = wdError_q;

endmodule

// File: doc/uart_report_scheduler.md
# uart_report_scheduler

Round-robin scheduler that shares the single decimal-ASCII UART transmit formatter (16-bit two's-complement value in, sign/digits/CR out) between several result producers, e.g. classifier output, heart-rate counter and debug taps. Each requester owns a one-entry holding slot. The scheduler picks one full slot, issues a single start pulse to the formatter, and holds the data stable until the formatter reports idle again. It sits between the inference/measurement blocks and the formatter instance in the top level.

## Interface
- `N_REQ`, default 4: number of requesters, range 2–8.
- `DATA_W`, default 16: value width; must match the formatter input.
- `WD_CYCLES`, default 8: cycles allowed for the formatter to leave idle after a start pulse.

- `Clk` input 1: system clock.
- `Reset` input 1: synchronous, active-high reset.
- `req_valid` input N_REQ: per-requester offer of a value.
- `req_data` input N_REQ*DATA_W: requester i occupies bits [i*DATA_W +: DATA_W].
- `req_ready` output N_REQ: slot i is empty; a transfer happens when `req_valid[i] & req_ready[i]`.
- `fmt_data` output DATA_W: value driven to the formatter data input.
- `fmt_start` output 1: one-cycle start pulse to the formatter.
- `fmt_idle` input 1: formatter idle flag.
- `grant_id` output clog2(N_REQ): requester currently being sent.
- `busy` output 1: a transmission is in progress.
- `wd_error` output 1: sticky flag, set on a watchdog expiry.

## Operation
Slots:
- Slot i loads `req_data[i]` on a transfer and becomes full.
- Slot i is cleared only when its transmission completes.
- Each slot's load and clear are independent of the other slots.
- A full slot holds `req_ready[i]=0`. No data is ever dropped.

FSM states are IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
- **IDLE**: if any slot is full and `fmt_idle=1`, select the first full slot at or after `rr_ptr`, searching upward and wrapping N_REQ-1→0. Copy that slot to `fmt_data`, set `grant_id`, go to ISSUE.
- **ISSUE**: `fmt_start=1` for this cycle only. Go to WAIT_BUSY with the watchdog counter cleared.
- **WAIT_BUSY**: on `fmt_idle=0`, go to WAIT_DONE. If the counter reaches WD_CYCLES first, set `wd_error` and return to IDLE.
  - On a watchdog expiry the slot stays full and `rr_ptr` is unchanged, so the same requester is retried.
- **WAIT_DONE**: on `fmt_idle=1`, clear the granted slot, set `rr_ptr = grant_id+1` (mod N_REQ), go to IDLE.

Data and flag rules:
- `fmt_data` stays constant from IDLE exit until WAIT_DONE exit. The formatter samples the sign bit after its start cycle, so this hold is mandatory.
- `busy` is 1 in ISSUE, WAIT_BUSY and WAIT_DONE.
- `wd_error` clears only on `Reset`.
- A requester may refill its slot in the cycle after its slot clears.
- A new offer to a requester whose slot is being sent is stalled until the clear.

## Timing
Reset values:
- `fmt_start=0`, `fmt_data=0`, `grant_id=0`, `busy=0`, `wd_error=0`.
- All slots empty, so `req_ready` is all ones.
- `rr_ptr=0`, state IDLE.

Reset mid-transmission:
- Abandons the value and clears every slot.
- The formatter finishes its current frame on its own. The scheduler does not issue a new start until it sees `fmt_idle=1`.

Cycle-level behaviour:
- Latency from slot full (cycle t) with the formatter idle to `fmt_start`: IDLE at t+1, ISSUE at t+2.
- Minimum gap between consecutive start pulses is 4 cycles plus the formatter's busy time.
- Simultaneous slot load and grant evaluation in the same cycle: the new value is not visible until the next cycle.
- A slot clear and a new load for the same slot in the same cycle cannot occur, because `req_ready` is 0 during the clear cycle.

## Configuration
- `UART_SCHED_PRIO0_EN` defined: requester 0 has fixed priority. If slot 0 is full in IDLE, it is granted regardless of `rr_ptr`. The remaining requesters rotate round-robin among themselves, and `rr_ptr` is not updated by grants to requester 0.
- Not defined: pure round-robin over all N_REQ requesters.

## Test plan
- **Single request.** Reset, then `req_valid[2]=1` with 0xFF85 (−123).
  - One `fmt_start` pulse, `fmt_data=0xFF85` and `grant_id=2` held until `fmt_idle` rises.
  - `req_ready[2]` returns to 1 one cycle after `fmt_idle` rises.
- **Fairness.** All four slots loaded in the same cycle (values 1, 2, 3, 4) with `rr_ptr=0`.
  - Grants in order 0,1,2,3, each with exactly one start pulse.
  - Refill slot 0 immediately; its next grant comes only after 3.
- **Back-pressure.** Requester 1 keeps `req_valid` high with changing data while its slot is full.
  - `req_ready[1]=0` throughout; the sent value is the first accepted one (e.g. 0x0007).
- **Watchdog.** Hold the `fmt_idle` model at 1 (ignore the start pulse).
  - After 8 cycles `wd_error=1` and the state returns to IDLE.
  - The same requester is retried; the slot is still full.
- **Reset mid-frame.** Assert `Reset` in WAIT_DONE.
  - Next cycle all outputs are at reset values and all slots are empty.
  - No `fmt_start` until `fmt_idle=1` and a new request arrives.
- **Priority build.** With `UART_SCHED_PRIO0_EN`, slots 0 and 3 are full, `rr_ptr=3`: slot 0 is granted first.
